segmented_adder_controller: RTL and testbench

SEGMENTED_ADDER_CONTROLLER -- requirements
Module: segmented_adder_controller

---
 rtl/adder_pkg.sv | 20 ++
 rtl/lookahead_carry_unit.sv | 48 ++++
 rtl/segmented_adder_controller.sv | 148 ++++++++++++++
 tb/tb_segmented_adder_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adder_pkg
//  Brief    : Shared state encodings and default geometry for the segmented
//             adder controller and its lookahead carry datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package adder_pkg;

    localparam int c_DEFAULT_WIDTH    = 8;
    localparam int c_DEFAULT_SEGMENTS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/lookahead_carry_unit.sv
`default_nettype none
// ============================================================================
//  Module   : lookahead_carry_unit
//  Brief    : Combinational carry-lookahead for one WIDTH-bit segment. Produces
//             the carry into every bit position plus the segment carry out.
//             Each carry is the flattened generate/propagate expression rather
//             than a ripple chain.
//  Revision : 1.0 - initial release
// ============================================================================
module lookahead_carry_unit
    import adder_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] carries,
    output logic             carry_out
);

    logic [WIDTH-1:0] w_gen;
    logic [WIDTH-1:0] w_prop;
    logic [WIDTH:0]   w_c;

    assign w_gen  = a & b;
    assign w_prop = a ^ b;
    assign w_c[0] = carry_in;

    // c[i] = OR over j<i of (g[j] & p[j+1..i-1]), plus carry_in & p[0..i-1]
    for (genvar i = 1; i <= WIDTH; i++) begin : g_carry
        logic [i:0] w_terms;
        for (genvar j = 0; j < i; j++) begin : g_term
            if (j == i - 1) begin : g_direct
                assign w_terms[j] = w_gen[j];
            end else begin : g_chain
                assign w_terms[j] = w_gen[j] & (&w_prop[i-1:j+1]);
            end
        end
        assign w_terms[i] = carry_in & (&w_prop[i-1:0]);
        assign w_c[i]     = |w_terms;
    end

    assign carries   = w_c[WIDTH-1:0];
    assign carry_out = w_c[WIDTH];

endmodule : lookahead_carry_unit
`default_nettype wire

// File: rtl/segmented_adder_controller.sv
`default_nettype none
// ============================================================================
//  Module   : segmented_adder_controller
//  Brief    : Multi-cycle N-bit adder (N = WIDTH*SEGMENTS). Operands are
//             latched on accept, then one WIDTH-bit segment is summed per
//             cycle through a single lookahead carry unit, LSB segment first,
//             with the segment carry chained through a register. The result
//             is held in DONE until the consumer takes it.
//  Revision : 1.0 - initial release
// ============================================================================
module segmented_adder_controller
    import adder_pkg::*;
#(
    parameter int WIDTH    = c_DEFAULT_WIDTH,
    parameter int SEGMENTS = c_DEFAULT_SEGMENTS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*SEGMENTS-1:0] a,
    input  logic [WIDTH*SEGMENTS-1:0] b,
    input  logic                      carry_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*SEGMENTS-1:0] sum,
    output logic                      carry_out,
    output logic                      overflow,
    output logic                      busy
);

    localparam int c_N     = WIDTH * SEGMENTS;
    localparam int c_IDX_W = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(SEGMENTS - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic               w_accept;
    logic               w_last;

    logic [c_N-1:0]     r_a;
    logic [c_N-1:0]     r_b;
    logic [c_N-1:0]     r_sum;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;

    logic [WIDTH-1:0]   w_seg_a;
    logic [WIDTH-1:0]   w_seg_b;
    logic [WIDTH-1:0]   w_seg_carries;
    logic [WIDTH-1:0]   w_seg_sum;
    logic               w_seg_cout;

    assign w_last = (r_idx == c_LAST_IDX);

    // State register; reset wins over any accept or handoff
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                w_accept = in_valid;
                if (in_valid) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Current segment of each operand, selected by the segment index
    assign w_seg_a   = r_a[r_idx*WIDTH +: WIDTH];
    assign w_seg_b   = r_b[r_idx*WIDTH +: WIDTH];
    assign w_seg_sum = w_seg_a ^ w_seg_b ^ w_seg_carries;

    lookahead_carry_unit #(
        .WIDTH (WIDTH)
    ) u_lcu (
        .a         (w_seg_a),
        .b         (w_seg_b),
        .carry_in  (r_carry),
        .carries   (w_seg_carries),
        .carry_out (w_seg_cout)
    );

    // Operand capture on accept, then one segment per RUN cycle; flags are
    // taken from the final segment, whose bit WIDTH-1 carry is the MSB carry-in
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_idx   <= '0;
            r_carry <= carry_in;
        end else if (r_state == ST_RUN) begin
            r_sum[r_idx*WIDTH +: WIDTH] <= w_seg_sum;
            r_carry                     <= w_seg_cout;
            if (w_last) begin
                r_idx  <= '0;
                r_cout <= w_seg_cout;
                r_ovf  <= w_seg_carries[WIDTH-1] ^ w_seg_cout;
            end else begin
                r_idx  <= r_idx + c_IDX_W'(1);
            end
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;

endmodule : segmented_adder_controller
`default_nettype wire

// File: tb/tb_segmented_adder_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_segmented_adder_controller
//  Brief    : Directed self-checking bench for segmented_adder_controller
//             (WIDTH=8, SEGMENTS=4): table of hand-computed additions plus
//             handshake, hold, reset and operand-isolation sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_segmented_adder_controller;

    localparam int c_WIDTH    = 8;
    localparam int c_SEGMENTS = 4;
    localparam int c_N        = c_WIDTH * c_SEGMENTS;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [c_N-1:0] a;
    logic [c_N-1:0] b;
    logic           carry_in;
    logic           out_valid;
    logic           out_ready;
    logic [c_N-1:0] sum;
    logic           carry_out;
    logic           overflow;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[7];

    segmented_adder_controller #(
        .WIDTH    (c_WIDTH),
        .SEGMENTS (c_SEGMENTS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for in_ready, then presents operands for one accept edge
    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc);
        int t;
        t = 0;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        chk("in_ready_before_accept", 64'(in_ready), 64'd1);
        a        = ta;
        b        = tb;
        carry_in = tc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid rises (bounded)
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic [31:0] held_sum;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[2] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};
        vecs[3] = '{32'h12345678, 32'h0FEDCBA8, 1'b1, 32'h22222221, 1'b0, 1'b0};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[6] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        chk("reset_in_ready",  64'(in_ready),  64'd1);
        chk("reset_busy",      64'(busy),      64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sum",       64'(sum),       64'd0);
        chk("reset_carry_out", 64'(carry_out), 64'd0);
        chk("reset_overflow",  64'(overflow),  64'd0);

        // Table-driven additions with immediate handoff
        for (int i = 0; i < 7; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
            chk($sformatf("vec%0d_busy_run", i), 64'(busy), 64'd1);
            wait_done(lat);
            chk($sformatf("vec%0d_latency", i),   64'(lat),       64'(c_SEGMENTS));
            chk($sformatf("vec%0d_sum", i),       64'(sum),       64'(vecs[i].sum));
            chk($sformatf("vec%0d_carry_out", i), 64'(carry_out), 64'(vecs[i].cout));
            chk($sformatf("vec%0d_overflow", i),  64'(overflow),  64'(vecs[i].ovf));
            chk($sformatf("vec%0d_in_ready_done", i), 64'(in_ready), 64'd0);
            tick();
            chk($sformatf("vec%0d_in_ready_after", i),  64'(in_ready),  64'd1);
            chk($sformatf("vec%0d_out_valid_after", i), 64'(out_valid), 64'd0);
            chk($sformatf("vec%0d_sum_retained", i),    64'(sum),       64'(vecs[i].sum));
        end

        // Consumer stalls three cycles in DONE: outputs hold, no new accept
        out_ready = 1'b0;
        start_op(32'h12345678, 32'h0FEDCBA8, 1'b1);
        wait_done(lat);
        chk("hold_latency", 64'(lat), 64'(c_SEGMENTS));
        held_sum = 32'h22222221;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold%0d_out_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("hold%0d_sum", k),       64'(sum),       64'(held_sum));
            chk($sformatf("hold%0d_in_ready", k),  64'(in_ready),  64'd0);
            tick();
        end
        in_valid  = 1'b0;
        chk("hold_final_sum", 64'(sum), 64'(held_sum));
        out_ready = 1'b1;
        tick();
        chk("hold_release_in_ready",  64'(in_ready),  64'd1);
        chk("hold_release_out_valid", 64'(out_valid), 64'd0);

        // Operand inputs toggling during RUN must not disturb the result
        start_op(32'h7FFFFFFF, 32'h00000001, 1'b0);
        in_valid = 1'b1;
        lat = 0;
        while (!out_valid && lat < 50) begin
            a        = $urandom;
            b        = $urandom;
            carry_in = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk("iso_latency",   64'(lat),       64'(c_SEGMENTS));
        chk("iso_sum",       64'(sum),       64'h80000000);
        chk("iso_carry_out", 64'(carry_out), 64'd0);
        chk("iso_overflow",  64'(overflow),  64'd1);
        tick();

        // Reset two cycles after accept discards the operation
        start_op(32'h11111111, 32'h22222222, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy",      64'(busy),      64'd0);
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_sum",       64'(sum),       64'd0);
        chk("rst_mid_in_ready",  64'(in_ready),  64'd1);
        lat = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) lat++;
            tick();
        end
        chk("rst_mid_no_pulse", 64'(lat), 64'd0);

        // Reset takes priority over an accept in the same cycle
        a        = 32'h00000005;
        b        = 32'h00000003;
        in_valid = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_prio_busy",     64'(busy),     64'd0);
        chk("rst_prio_in_ready", 64'(in_ready), 64'd1);

        // Fresh operation after reset completes correctly
        start_op(32'hFFFFFFFF, 32'h00000001, 1'b0);
        wait_done(lat);
        chk("post_rst_latency",   64'(lat),       64'(c_SEGMENTS));
        chk("post_rst_sum",       64'(sum),       64'h00000000);
        chk("post_rst_carry_out", 64'(carry_out), 64'd1);
        chk("post_rst_overflow",  64'(overflow),  64'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_segmented_adder_controller
`default_nettype wire
